mitchell_etm_pipe: RTL and testbench

//  Pipelined, parametrised Mitchell-log error-tolerant multiplier (ETM) with valid/ready handshake.

---
 rtl/mitchell_etm_pipe_if.sv | 37 +++
 rtl/mitchell_etm_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_mitchell_etm_pipe.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mitchell_etm_pipe_if.sv
// Operand / product handshake bundle for the Mitchell error-tolerant multiplier.
// master = operand producer and product consumer, slave = the multiplier itself.
// Operands are WIDTH bits; the product is 2*WIDTH bits plus an exact-path flag.
interface mitchell_etm_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] c;
  logic               c_exact;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  c,
    input  c_exact
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output c,
    output c_exact
  );
endinterface

// File: rtl/mitchell_etm_pipe.sv
// Mitchell log/antilog multiplier with an exact path for small operands, plus exact/approx delivery counters.
// Latency: 3 stages; a pair accepted in cycle N is presented in cycle N+3; one result per cycle when unstalled.
// Backpressure: global stall, in_ready = !out_valid | out_ready; every stage holds while the output is blocked.
module mitchell_etm_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8,
  parameter int FRAC  = WIDTH - 1,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mitchell_etm_pipe_if.slave bus,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   n_exact,
  output logic [CNT_W-1:0]   n_approx
);

  // Leading-one position width, exponent width (k1+k2+carry <= 2*WIDTH-1),
  // product width, exact-product width, and the no-overflow antilog window.
  localparam int KW = $clog2(WIDTH);
  localparam int EW = $clog2(2 * WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int LW = 2 * SPLIT;
  localparam int XW = PW + FRAC + 1;
  localparam logic [KW-1:0] KMAX = KW'(WIDTH - 1);

  // Position of the most significant set bit; 0 for a zero operand
  // (the zero flag covers that case downstream).
  function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = KW'(i);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic adv;
  logic deliver;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign deliver      = bus.out_valid && bus.out_ready;

  // ---------------------------------------------------------------------
  // Stage 1: classify operands, leading-one detect, extract fractions
  // ---------------------------------------------------------------------
  logic [KW-1:0]    k1_d, k2_d;
  logic [WIDTH-1:0] n1_d, n2_d;
  logic             ex_d;
  logic             zero_d;

  logic             s1_vld;
  logic             s1_ex;
  logic             s1_zero;
  logic [SPLIT-1:0] s1_a_lo, s1_b_lo;
  logic [KW-1:0]    s1_k1, s1_k2;
  logic [FRAC-1:0]  s1_x1, s1_x2;

  // Normalise each operand so its leading one sits in the MSB; the bits just
  // below it are the Mitchell fraction, and a clear MSB means the operand is 0.
  always_comb begin
    k1_d   = lod(bus.a);
    k2_d   = lod(bus.b);
    n1_d   = bus.a << (KMAX - k1_d);
    n2_d   = bus.b << (KMAX - k2_d);
    ex_d   = (bus.a[WIDTH-1:SPLIT] == '0) && (bus.b[WIDTH-1:SPLIT] == '0);
    zero_d = !(n1_d[WIDTH-1] && n2_d[WIDTH-1]);
  end

  // Stage-1 occupancy: a bubble enters whenever the pipe advances without a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
    end else if (adv) begin
      s1_vld <= bus.in_valid;
    end
  end

  // Stage-1 payload, loaded only for real transfers to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ex   <= 1'b0;
      s1_zero <= 1'b0;
      s1_a_lo <= '0;
      s1_b_lo <= '0;
      s1_k1   <= '0;
      s1_k2   <= '0;
      s1_x1   <= '0;
      s1_x2   <= '0;
    end else if (adv && bus.in_valid) begin
      s1_ex   <= ex_d;
      s1_zero <= zero_d;
      s1_a_lo <= bus.a[SPLIT-1:0];
      s1_b_lo <= bus.b[SPLIT-1:0];
      s1_k1   <= k1_d;
      s1_k2   <= k2_d;
      s1_x1   <= n1_d[WIDTH-2 -: FRAC];
      s1_x2   <= n2_d[WIDTH-2 -: FRAC];
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: exact low product and Mitchell log-domain add
  // ---------------------------------------------------------------------
  logic [LW-1:0]   p_d;
  logic [FRAC:0]   s_d;
  logic [FRAC:0]   mant_d;
  logic [EW-1:0]   e_d;

  logic            s2_vld;
  logic            s2_ex;
  logic            s2_zero;
  logic [LW-1:0]   s2_p;
  logic [FRAC:0]   s2_mant;
  logic [EW-1:0]   s2_e;

  // Fraction sum with carry: without carry the mantissa is 1.s, with carry the
  // sum itself already reads as 1.x at one higher exponent.
  always_comb begin
    p_d    = LW'(s1_a_lo) * LW'(s1_b_lo);
    s_d    = {1'b0, s1_x1} + {1'b0, s1_x2};
    mant_d = s_d[FRAC] ? s_d : {1'b1, s_d[FRAC-1:0]};
    e_d    = EW'(s1_k1) + EW'(s1_k2) + EW'(s_d[FRAC]);
  end

  // Stage-2 occupancy follows stage 1 whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
    end else if (adv) begin
      s2_vld <= s1_vld;
    end
  end

  // Stage-2 payload, captured only when a valid operand pair moves forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ex   <= 1'b0;
      s2_zero <= 1'b0;
      s2_p    <= '0;
      s2_mant <= '0;
      s2_e    <= '0;
    end else if (adv && s1_vld) begin
      s2_ex   <= s1_ex;
      s2_zero <= s1_zero;
      s2_p    <= p_d;
      s2_mant <= mant_d;
      s2_e    <= e_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: antilog and result select
  // ---------------------------------------------------------------------
  logic [XW-1:0] wide_d;
  logic [PW-1:0] c_d;

  // The shift window holds mant<<e without loss, so dropping FRAC bits
  // truncates toward zero; exact wins over zero (0*small is still exact).
  always_comb begin
    wide_d = XW'(s2_mant) << s2_e;
    c_d    = PW'(wide_d >> FRAC);
    if (s2_ex) begin
      c_d = PW'(s2_p);
    end else if (s2_zero) begin
      c_d = '0;
    end
  end

  // Output valid: drops when a bubble arrives, holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s2_vld;
    end
  end

  // Output payload: updated only by a real result, so c stays put under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.c       <= '0;
      bus.c_exact <= 1'b0;
    end else if (adv && s2_vld) begin
      bus.c       <= c_d;
      bus.c_exact <= s2_ex;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------

  // Count delivered products by path; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_exact  <= '0;
      n_approx <= '0;
    end else if (clr_stats) begin
      n_exact  <= '0;
      n_approx <= '0;
    end else if (deliver) begin
      if (bus.c_exact) begin
        n_exact <= n_exact + CNT_W'(1);
      end else begin
        n_approx <= n_approx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mitchell_etm_pipe.sv
// Directed + random bench for mitchell_etm_pipe with an arithmetic reference model.
// Model works on real fractions (op - 2^k)/2^k; a negedge process scores every delivery.
module tb_mitchell_etm_pipe;
  localparam int WIDTH = 16;
  localparam int SPLIT = 8;
  localparam int FRAC  = WIDTH - 1;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             clr_stats;
  logic [CNT_W-1:0] n_exact;
  logic [CNT_W-1:0] n_approx;

  mitchell_etm_pipe_if #(.WIDTH(WIDTH)) bus ();

  mitchell_etm_pipe #(
    .WIDTH(WIDTH),
    .SPLIT(SPLIT),
    .FRAC (FRAC),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_stats(clr_stats),
    .n_exact  (n_exact),
    .n_approx (n_approx)
  );

  typedef struct {
    logic [63:0] c;
    logic        ex;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  int ta[10] = '{200, 1000, 0,     65535, 4096, 7, 3, 1000, 300, 255};
  int tb[10] = '{100, 1000, 60000, 65535, 256,  9, 4, 1000, 2,   255};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int flog2(input longint unsigned v);
    int r;
    r = 0;
    while ((v >> (r + 1)) != 0) r++;
    return r;
  endfunction

  // Mitchell: a*b ~= 2^(k1+k2) * (1 + f1 + f2), or 2^(k1+k2+1) * (f1 + f2) when f1+f2 >= 1.
  function automatic exp_t model(input longint unsigned a, input longint unsigned b);
    exp_t r;
    longint unsigned one, f1, f2, s;
    int k1, k2;
    one  = 64'd1 << FRAC;
    r.ex = (a < (64'd1 << SPLIT)) && (b < (64'd1 << SPLIT));
    if (r.ex) begin
      r.c = a * b;
    end else if (a == 0 || b == 0) begin
      r.c = 0;
    end else begin
      k1 = flog2(a);
      k2 = flog2(b);
      f1 = ((a - (64'd1 << k1)) << FRAC) >> k1;
      f2 = ((b - (64'd1 << k2)) << FRAC) >> k2;
      s  = f1 + f2;
      if (s < one) r.c = ((one + s) << (k1 + k2)) >> FRAC;
      else         r.c = (s << (k1 + k2 + 1)) >> FRAC;
    end
    return r;
  endfunction

  // Scoreboard: predict on accept, compare on delivery, track counters and stall hold.
  initial begin
    exp_t             e;
    logic [CNT_W-1:0] m_ex, m_ap;
    logic             held, held_x;
    logic [63:0]      held_c;
    m_ex = '0; m_ap = '0; held = 1'b0; held_x = 1'b0; held_c = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_ex = '0;
        m_ap = '0;
        held = 1'b0;
      end else begin
        check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        check("n_exact", n_exact, m_ex);
        check("n_approx", n_approx, m_ap);
        if (held) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_c", bus.c, held_c);
          check("hold_c_exact", bus.c_exact, held_x);
        end
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b));
        if (bus.out_valid && bus.out_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_out: got c=%0d with no pending operands, expected none", bus.c);
          end else begin
            e = q.pop_front();
            check("c", bus.c, e.c);
            check("c_exact", bus.c_exact, e.ex);
            if (e.ex) m_ex = m_ex + 1;
            else      m_ap = m_ap + 1;
          end
        end
        if (clr_stats) begin
          m_ex = '0;
          m_ap = '0;
        end
        held   = bus.out_valid && !bus.out_ready;
        held_c = bus.c;
        held_x = bus.c_exact;
      end
    end
  end

  // One isolated pair: latency counted in edges from the accept edge to out_valid.
  task automatic run_single(input int ia, input int ib, input logic [63:0] exp_c,
                            input logic exp_x, input string nm);
    int lat;
    @(posedge clk); #1;
    bus.a = ia[WIDTH-1:0]; bus.b = ib[WIDTH-1:0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 3);
    check({nm, "_c"}, bus.c, exp_c);
    check({nm, "_c_exact"}, bus.c_exact, exp_x);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t m;
    int   idx, dcnt, ra, rb, sel, tries, cyc;
    logic fin, fout, acc;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    clr_stats = 1'b0; rst_n = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_c", bus.c, 0);
    check("rst_c_exact", bus.c_exact, 0);
    check("rst_n_exact", n_exact, 0);
    check("rst_n_approx", n_approx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // Hand-worked values that pin the reference model.
    m = model(200, 100);     check("model_exact", m.c, 20000);
    m = model(1000, 1000);   check("model_carry", m.c, 999424);
    m = model(65535, 65535); check("model_max", m.c, 64'd4294836224);
    m = model(4096, 256);    check("model_pow2", m.c, 1048576);
    m = model(300, 2);       check("model_nocarry", m.c, 512 + (512 * 44) / 256);

    // Exact path, Mitchell carry, zero, extremes, boundaries around SPLIT.
    run_single(200, 100, 20000, 1'b1, "t1");
    check("t1_n_exact", n_exact, 1);
    check("t1_n_approx", n_approx, 0);
    run_single(1000, 1000, 999424, 1'b0, "t2");
    check("t2_n_approx", n_approx, 1);
    run_single(0, 60000, 0, 1'b0, "t3_zero");
    run_single(65535, 65535, 64'd4294836224, 1'b0, "t3_max");
    run_single(4096, 256, 1048576, 1'b0, "t3_pow2");
    run_single(0, 5, 0, 1'b1, "zero_exact_prio");
    run_single(255, 255, 65025, 1'b1, "split_edge_exact");
    run_single(256, 1, 256, 1'b0, "split_edge_approx");

    // Backpressure: out_ready low in relative cycles 2..6 while five pairs stream.
    idx = 0; dcnt = 0; fin = 1'b0; fout = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (fin) idx++;
      if (fout) dcnt++;
      if (dcnt == 5) break;
      bus.in_valid  = (idx < 5);
      bus.a         = ta[idx][WIDTH-1:0];
      bus.b         = tb[idx][WIDTH-1:0];
      bus.out_ready = !(t >= 2 && t <= 6);
      #1;
      fin  = bus.in_valid && bus.in_ready;
      fout = bus.out_valid && bus.out_ready;
      if (t == 4) check("t4_stall_in_ready", bus.in_ready, 0);
      if (t == 4) check("t4_stall_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    check("t4_delivered", dcnt, 5);
    check("t4_queue_empty", q.size(), 0);

    // Asynchronous reset with a stalled result and a second pair in flight.
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.a = 200; bus.b = 100; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 1000; bus.b = 1000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_pre_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_c", bus.c, 0);
    check("t5_c_exact", bus.c_exact, 0);
    check("t5_n_exact", n_exact, 0);
    check("t5_n_approx", n_approx, 0);
    check("t5_in_ready", bus.in_ready, 1);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t5_no_output", bus.out_valid, 0);
    end
    check("t5_cnt_after", n_exact + n_approx, 0);

    // Ten deliveries, clear on the sixth: only deliveries 7..10 remain counted.
    idx = 0; dcnt = 0; fin = 1'b0; fout = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (fin) idx++;
      if (fout) dcnt++;
      if (dcnt == 10) break;
      bus.in_valid = (idx < 10);
      bus.a        = ta[idx < 10 ? idx : 0][WIDTH-1:0];
      bus.b        = tb[idx < 10 ? idx : 0][WIDTH-1:0];
      #1;
      fin       = bus.in_valid && bus.in_ready;
      fout      = bus.out_valid && bus.out_ready;
      clr_stats = fout && (dcnt == 5);
    end
    clr_stats = 1'b0; bus.in_valid = 1'b0;
    check("t6_delivered", dcnt, 10);
    check("t6_total", n_exact + n_approx, 4);
    check("t6_n_exact", n_exact, 2);
    check("t6_n_approx", n_approx, 2);

    // Random operands with random bubbles and random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom_range(0, 65535);
      rb  = $urandom_range(0, 65535);
      if (sel < 3) begin
        ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
      end else if (sel == 3) begin
        if ($urandom_range(0, 1) == 1) ra = 0; else rb = 0;
      end else if (sel == 4) begin
        ra = 1 << $urandom_range(0, 15); rb = 1 << $urandom_range(0, 15);
      end
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = ($urandom_range(0, 1) == 1);
      end
      acc = 1'b0; tries = 0;
      while (!acc && tries < 50) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.a = ra[WIDTH-1:0]; bus.b = rb[WIDTH-1:0];
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = bus.in_ready;
        tries++;
      end
      check("rand_accept", acc, 1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || bus.out_valid) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
